smc_serial_loader: RTL

//  Upstream feeder for the SMC combinational core.
//  - Accepts one MOSFET descriptor (W, V_GS, V_DS) per handshake beat; six beats make one packet.
//  - Presents the assembled packet to SMC as a stable parallel bundle.
//  - Samples SMC out_n after a fixed settle cycle and returns it through a valid/ready result port.

---
 rtl/smc_serial_loader.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/smc_serial_loader.sv
// Serial-to-parallel feeder for SMC: six (W, V_GS, V_DS) beats form one packet, out_n returns via valid/ready.
// Result valid 2 cycles after the last beat; in_ready stays low from EVAL until the result is consumed.
module smc_serial_loader #(
  parameter int NUM_FET = 6,
  parameter int DATA_W  = 3,
  parameter int OUT_W   = 8,
  parameter int GAP_MAX = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_mode,
  input  logic [DATA_W-1:0] in_w,
  input  logic [DATA_W-1:0] in_vgs,
  input  logic [DATA_W-1:0] in_vds,
  output logic [1:0]        mode,
  output logic [DATA_W-1:0] W_0,
  output logic [DATA_W-1:0] W_1,
  output logic [DATA_W-1:0] W_2,
  output logic [DATA_W-1:0] W_3,
  output logic [DATA_W-1:0] W_4,
  output logic [DATA_W-1:0] W_5,
  output logic [DATA_W-1:0] V_GS_0,
  output logic [DATA_W-1:0] V_GS_1,
  output logic [DATA_W-1:0] V_GS_2,
  output logic [DATA_W-1:0] V_GS_3,
  output logic [DATA_W-1:0] V_GS_4,
  output logic [DATA_W-1:0] V_GS_5,
  output logic [DATA_W-1:0] V_DS_0,
  output logic [DATA_W-1:0] V_DS_1,
  output logic [DATA_W-1:0] V_DS_2,
  output logic [DATA_W-1:0] V_DS_3,
  output logic [DATA_W-1:0] V_DS_4,
  output logic [DATA_W-1:0] V_DS_5,
  input  logic [OUT_W-1:0]  smc_out_n,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_n,
  output logic              pkt_drop
);

  localparam int         GAP_W = (GAP_MAX > 0) ? $clog2(GAP_MAX + 1) : 1;
  localparam logic [2:0] LAST  = 3'(NUM_FET - 1);

  typedef enum logic [1:0] {
    COLLECT,
    EVAL,
    HOLD
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        beat_cnt_q, beat_cnt_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [2:0]        slot;
  logic              beat;
  logic              timeout;

  logic [DATA_W-1:0] w_q   [NUM_FET];
  logic [DATA_W-1:0] vgs_q [NUM_FET];
  logic [DATA_W-1:0] vds_q [NUM_FET];

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    in_ready   = 1'b0;
    beat       = 1'b0;
    timeout    = 1'b0;
    slot       = beat_cnt_q;
    case (state_q)
      COLLECT: begin
        in_ready = 1'b1;
        beat     = in_valid;
        timeout  = (GAP_MAX > 0) && (gap_cnt_q == GAP_W'(GAP_MAX));
        // A beat landing on the timeout cycle restarts the packet at slot 0
        slot     = timeout ? 3'd0 : beat_cnt_q;
        if (beat) begin
          gap_cnt_d = '0;
          if (slot == LAST) begin
            beat_cnt_d = '0;
            state_d    = EVAL;
          end else begin
            beat_cnt_d = slot + 3'd1;
          end
        end else if (timeout) begin
          beat_cnt_d = '0;
          gap_cnt_d  = '0;
        end else if ((GAP_MAX > 0) && (beat_cnt_q != '0)) begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      EVAL:    state_d = HOLD;
      HOLD:    if (out_ready) state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= COLLECT;
      beat_cnt_q <= '0;
      gap_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode  <= '0;
      out_n <= '0;
      for (int i = 0; i < NUM_FET; i++) begin
        w_q[i]   <= '0;
        vgs_q[i] <= '0;
        vds_q[i] <= '0;
      end
    end else begin
      if (beat) begin
        w_q[slot]   <= in_w;
        vgs_q[slot] <= in_vgs;
        vds_q[slot] <= in_vds;
        if (slot == 3'd0) mode <= in_mode;
      end
      if (state_q == EVAL) out_n <= smc_out_n;
    end
  end

  assign out_valid = (state_q == HOLD);
  assign pkt_drop  = timeout;

  assign W_0    = w_q[0];
  assign W_1    = w_q[1];
  assign W_2    = w_q[2];
  assign W_3    = w_q[3];
  assign W_4    = w_q[4];
  assign W_5    = w_q[5];
  assign V_GS_0 = vgs_q[0];
  assign V_GS_1 = vgs_q[1];
  assign V_GS_2 = vgs_q[2];
  assign V_GS_3 = vgs_q[3];
  assign V_GS_4 = vgs_q[4];
  assign V_GS_5 = vgs_q[5];
  assign V_DS_0 = vds_q[0];
  assign V_DS_1 = vds_q[1];
  assign V_DS_2 = vds_q[2];
  assign V_DS_3 = vds_q[3];
  assign V_DS_4 = vds_q[4];
  assign V_DS_5 = vds_q[5];

endmodule
